// File: rtl/mem_stage.sv
// Pipeline MEM stage: registers EXE results, waits for load data, extracts
// bytes/halfwords, merges LWL/LWR and selects the writeback value.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_valid_in,
  output logic        mem_allowin_out,
  input  logic        wb_allowin_in,
  output logic        mem_valid_out,
  input  logic [31:0] exe_alures_in,
  input  logic [4:0]  exe_sel_wbdata_in,
  input  logic [4:0]  exe_lubhw_con_in,
  input  logic [7:0]  exe_onehot_in,
  input  logic [31:0] exe_rt_in,
  input  logic [31:0] exe_PC_in,
  input  logic [31:0] exe_NNPC_in,
  input  logic [4:0]  exe_wnum_in,
  input  logic [2:0]  exe_write_type_in,
  input  logic [31:0] dm_rdata_in,
  input  logic        dm_data_ok_in,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [31:0] mem_wbdata_out,
  output logic [4:0]  mem_wnum_out,
  output logic [2:0]  mem_write_type_out,
  output logic [31:0] mem_PC_out,
  output logic [1:0]  dbg_state_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_valid;
  logic [31:0] r_alures;
  logic [4:0]  r_sel_wbdata;
  logic [4:0]  r_lubhw;
  logic [7:0]  r_onehot;
  logic [31:0] r_rt;
  logic [31:0] r_pc;
  logic [31:0] r_nnpc;
  logic [4:0]  r_wnum;
  logic [2:0]  r_write_type;
  logic [31:0] r_buf;

  logic        w_ready;
  logic        w_accept;
  logic        w_in_is_load;
  logic        w_buf_load;
  logic [31:0] w_mem;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  // Handshake: a side transfers on a cycle where its valid and the receiver's
  // allowin are both high; valid never waits on allowin.
  always_comb begin
    w_ready = 1'b1;
    case (r_state)
      S_WAIT:  w_ready = dm_data_ok_in;
      default: w_ready = 1'b1;
    endcase
  end

  assign mem_allowin_out = !r_valid || (w_ready && wb_allowin_in);
  assign mem_valid_out   = r_valid && w_ready;
  assign w_accept        = mem_allowin_out && exe_valid_in;
  // The incoming fields decide the next state, since they are only registered at this edge.
  assign w_in_is_load    = (|exe_lubhw_con_in) || (|exe_onehot_in);
  assign dbg_state_out   = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_buf_load  = 1'b0;
    if (mem_allowin_out) begin
      w_state_nxt = (w_accept && w_in_is_load) ? S_WAIT : S_IDLE;
    end else if (r_state == S_WAIT && dm_data_ok_in) begin
      w_state_nxt = S_DONE;
      w_buf_load  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_valid      <= 1'b0;
      r_alures     <= 32'h0;
      r_sel_wbdata <= 5'h0;
      r_lubhw      <= 5'h0;
      r_onehot     <= 8'h0;
      r_rt         <= 32'h0;
      r_pc         <= 32'h0;
      r_nnpc       <= 32'h0;
      r_wnum       <= 5'h0;
      r_write_type <= 3'h0;
      r_buf        <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (mem_allowin_out) r_valid <= exe_valid_in;
      if (w_accept) begin
        r_alures     <= exe_alures_in;
        r_sel_wbdata <= exe_sel_wbdata_in;
        r_lubhw      <= exe_lubhw_con_in;
        r_onehot     <= exe_onehot_in;
        r_rt         <= exe_rt_in;
        r_pc         <= exe_PC_in;
        r_nnpc       <= exe_NNPC_in;
        r_wnum       <= exe_wnum_in;
        r_write_type <= exe_write_type_in;
      end
      if (w_buf_load) r_buf <= dm_rdata_in;
    end
  end

  // Once WB has stalled a completed load, the buffered word stands in for the bus.
  assign w_mem = (r_state == S_DONE) ? r_buf : dm_rdata_in;

  always_comb begin
    w_byte = w_mem[7:0];
    case (r_alures[1:0])
      2'd1:    w_byte = w_mem[15:8];
      2'd2:    w_byte = w_mem[23:16];
      2'd3:    w_byte = w_mem[31:24];
      default: w_byte = w_mem[7:0];
    endcase
  end

  assign w_half = r_alures[1] ? w_mem[31:16] : w_mem[15:0];

  always_comb begin
    w_load_data = 32'h0;
    if (r_lubhw[0])      w_load_data = w_mem;
    else if (r_lubhw[1]) w_load_data = {{24{w_byte[7]}}, w_byte};
    else if (r_lubhw[2]) w_load_data = {24'h0, w_byte};
    else if (r_lubhw[3]) w_load_data = {{16{w_half[15]}}, w_half};
    else if (r_lubhw[4]) w_load_data = {16'h0, w_half};
    else if (r_onehot[0]) w_load_data = {w_mem[7:0],  r_rt[23:0]};
    else if (r_onehot[1]) w_load_data = {w_mem[15:0], r_rt[15:0]};
    else if (r_onehot[2]) w_load_data = {w_mem[23:0], r_rt[7:0]};
    else if (r_onehot[3]) w_load_data = w_mem;
    else if (r_onehot[4]) w_load_data = w_mem;
    else if (r_onehot[5]) w_load_data = {r_rt[31:24], w_mem[31:8]};
    else if (r_onehot[6]) w_load_data = {r_rt[31:16], w_mem[31:16]};
    else if (r_onehot[7]) w_load_data = {r_rt[31:8],  w_mem[31:24]};
  end

  assign mem_wbdata_out = ({32{r_sel_wbdata[0]}} & r_alures)
                        | ({32{r_sel_wbdata[1]}} & w_load_data)
                        | ({32{r_sel_wbdata[2]}} & r_nnpc)
                        | ({32{r_sel_wbdata[3]}} & hi_in)
                        | ({32{r_sel_wbdata[4]}} & lo_in);

  assign mem_wnum_out       = r_wnum;
  assign mem_write_type_out = r_write_type;
  assign mem_PC_out         = r_pc;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a vector table of single instructions plus directed
// sequences for load wait, WB stall, buffered data and reset during WAIT.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        exe_valid_in;
  logic        mem_allowin_out;
  logic        wb_allowin_in;
  logic        mem_valid_out;
  logic [31:0] exe_alures_in;
  logic [4:0]  exe_sel_wbdata_in;
  logic [4:0]  exe_lubhw_con_in;
  logic [7:0]  exe_onehot_in;
  logic [31:0] exe_rt_in;
  logic [31:0] exe_PC_in;
  logic [31:0] exe_NNPC_in;
  logic [4:0]  exe_wnum_in;
  logic [2:0]  exe_write_type_in;
  logic [31:0] dm_rdata_in;
  logic        dm_data_ok_in;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic [31:0] mem_wbdata_out;
  logic [4:0]  mem_wnum_out;
  logic [2:0]  mem_write_type_out;
  logic [31:0] mem_PC_out;
  logic [1:0]  dbg_state_out;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .exe_valid_in(exe_valid_in), .mem_allowin_out(mem_allowin_out),
    .wb_allowin_in(wb_allowin_in), .mem_valid_out(mem_valid_out),
    .exe_alures_in(exe_alures_in), .exe_sel_wbdata_in(exe_sel_wbdata_in),
    .exe_lubhw_con_in(exe_lubhw_con_in), .exe_onehot_in(exe_onehot_in),
    .exe_rt_in(exe_rt_in), .exe_PC_in(exe_PC_in), .exe_NNPC_in(exe_NNPC_in),
    .exe_wnum_in(exe_wnum_in), .exe_write_type_in(exe_write_type_in),
    .dm_rdata_in(dm_rdata_in), .dm_data_ok_in(dm_data_ok_in),
    .hi_in(hi_in), .lo_in(lo_in),
    .mem_wbdata_out(mem_wbdata_out), .mem_wnum_out(mem_wnum_out),
    .mem_write_type_out(mem_write_type_out), .mem_PC_out(mem_PC_out),
    .dbg_state_out(dbg_state_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_q(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got 0x%08h expected <empty queue>", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  // drivers
  task automatic drive_exe(input logic v, input logic [4:0] sel, input logic [4:0] lubhw,
                           input logic [7:0] oh, input logic [31:0] alu, input logic [31:0] rt,
                           input logic [4:0] wnum, input logic [31:0] pc);
    exe_valid_in      = v;
    exe_sel_wbdata_in = sel;
    exe_lubhw_con_in  = lubhw;
    exe_onehot_in     = oh;
    exe_alures_in     = alu;
    exe_rt_in         = rt;
    exe_wnum_in       = wnum;
    exe_write_type_in = wnum[2:0];
    exe_PC_in         = pc;
  endtask

  task automatic idle_exe();
    drive_exe(1'b0, 5'h0, 5'h0, 8'h0, 32'h0, 32'h0, 5'h0, 32'h0);
  endtask

  typedef struct {
    string       name;
    logic [4:0]  sel;
    logic [4:0]  lubhw;
    logic [7:0]  oh;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic [4:0] sel, input logic [4:0] lubhw,
                              input logic [7:0] oh, input logic [31:0] alu, input logic [31:0] rt,
                              input logic [31:0] rdata, input logic [31:0] exp);
    vec_t v;
    v.name = n; v.sel = sel; v.lubhw = lubhw; v.oh = oh;
    v.alu = alu; v.rt = rt; v.rdata = rdata; v.exp = exp;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    wb_allowin_in = 1'b1;
    dm_rdata_in = 32'h0;
    dm_data_ok_in = 1'b0;
    hi_in = 32'hDEADBEEF;
    lo_in = 32'h12345678;
    exe_NNPC_in = 32'h0040_0008;
    idle_exe();

    vecs.push_back(mk("addu",    5'b00001, 5'b00000, 8'h00, 32'h0000_1234, 32'h0, 32'h0, 32'h0000_1234));
    vecs.push_back(mk("lb_a3",   5'b00010, 5'b00010, 8'h00, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 32'hFFFF_FF80));
    vecs.push_back(mk("lbu_a3",  5'b00010, 5'b00100, 8'h00, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 32'h0000_0080));
    vecs.push_back(mk("lb_a1",   5'b00010, 5'b00010, 8'h00, 32'h0000_1001, 32'h0, 32'h1122_7F44, 32'h0000_007F));
    vecs.push_back(mk("lh_a2",   5'b00010, 5'b01000, 8'h00, 32'h0000_1002, 32'h0, 32'h80FF_1234, 32'hFFFF_80FF));
    vecs.push_back(mk("lhu_a0",  5'b00010, 5'b10000, 8'h00, 32'h0000_1000, 32'h0, 32'h80FF_9234, 32'h0000_9234));
    vecs.push_back(mk("lw",      5'b00010, 5'b00001, 8'h00, 32'h0000_1000, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D));
    vecs.push_back(mk("lwl_a0",  5'b00010, 5'b00000, 8'h01, 32'h0000_1000, 32'hAABB_CCDD, 32'h1122_3344, 32'h44BB_CCDD));
    vecs.push_back(mk("lwl_a1",  5'b00010, 5'b00000, 8'h02, 32'h0000_1001, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD));
    vecs.push_back(mk("lwl_a3",  5'b00010, 5'b00000, 8'h08, 32'h0000_1003, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344));
    vecs.push_back(mk("lwr_a0",  5'b00010, 5'b00000, 8'h10, 32'h0000_1000, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344));
    vecs.push_back(mk("lwr_a2",  5'b00010, 5'b00000, 8'h40, 32'h0000_1002, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122));
    vecs.push_back(mk("lwr_a3",  5'b00010, 5'b00000, 8'h80, 32'h0000_1003, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CC11));
    vecs.push_back(mk("nnpc",    5'b00100, 5'b00000, 8'h00, 32'h0000_0055, 32'h0, 32'h0, 32'h0040_0008));
    vecs.push_back(mk("hi",      5'b01000, 5'b00000, 8'h00, 32'h0000_0055, 32'h0, 32'h0, 32'hDEAD_BEEF));
    vecs.push_back(mk("lo",      5'b10000, 5'b00000, 8'h00, 32'h0000_0055, 32'h0, 32'h0, 32'h1234_5678));
    vecs.push_back(mk("sel_zero",5'b00000, 5'b00000, 8'h00, 32'h0000_0055, 32'h0, 32'h0, 32'h0000_0000));

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid",   {31'h0, mem_valid_out}, 32'h0);
    check("rst_allowin", {31'h0, mem_allowin_out}, 32'h1);
    check("rst_state",   {30'h0, dbg_state_out}, {30'h0, ST_IDLE});
    check("rst_wbdata",  mem_wbdata_out, 32'h0);
    check("rst_pc",      mem_PC_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // table: each instruction accepted, then completed (loads get data_ok at once)
    foreach (vecs[i]) begin
      logic is_load;
      is_load = (|vecs[i].lubhw) || (|vecs[i].oh);
      drive_exe(1'b1, vecs[i].sel, vecs[i].lubhw, vecs[i].oh, vecs[i].alu, vecs[i].rt,
                5'(i + 1), 32'h0000_1000 + 32'(4 * i));
      exp_q.push_back(vecs[i].exp);
      @(negedge clk);
      idle_exe();
      if (is_load) begin
        #1;
        check({vecs[i].name, "_wait_valid"}, {31'h0, mem_valid_out}, 32'h0);
        dm_rdata_in = vecs[i].rdata;
        dm_data_ok_in = 1'b1;
      end
      #1;
      check({vecs[i].name, "_valid"}, {31'h0, mem_valid_out}, 32'h1);
      check_q(vecs[i].name, mem_wbdata_out);
      check({vecs[i].name, "_wnum"}, {27'h0, mem_wnum_out}, 32'(i + 1));
      check({vecs[i].name, "_wtype"}, {29'h0, mem_write_type_out}, 32'((i + 1) % 8));
      check({vecs[i].name, "_pc"}, mem_PC_out, 32'h0000_1000 + 32'(4 * i));
      @(negedge clk);
      dm_data_ok_in = 1'b0;
      dm_rdata_in = 32'h0;
    end

    // LB with data_ok two cycles late
    drive_exe(1'b1, 5'b00010, 5'b00010, 8'h00, 32'h0000_2003, 32'h0, 5'd7, 32'h0000_3000);
    @(negedge clk);
    idle_exe();
    for (int c = 0; c < 2; c++) begin
      #1;
      check("lb_late_valid", {31'h0, mem_valid_out}, 32'h0);
      check("lb_late_allowin", {31'h0, mem_allowin_out}, 32'h0);
      check("lb_late_state", {30'h0, dbg_state_out}, {30'h0, ST_WAIT});
      @(negedge clk);
    end
    dm_rdata_in = 32'h80FF_FFFF;
    dm_data_ok_in = 1'b1;
    #1;
    check("lb_late_valid_ok", {31'h0, mem_valid_out}, 32'h1);
    check("lb_late_data", mem_wbdata_out, 32'hFFFF_FF80);
    @(negedge clk);
    dm_data_ok_in = 1'b0;

    // LHU completes under WB stall, later drained from the buffer
    drive_exe(1'b1, 5'b00010, 5'b10000, 8'h00, 32'h0000_2002, 32'h0, 5'd8, 32'h0000_3004);
    @(negedge clk);
    idle_exe();
    wb_allowin_in = 1'b0;
    dm_rdata_in = 32'h80FF_1234;
    dm_data_ok_in = 1'b1;
    #1;
    check("lhu_stall_data", mem_wbdata_out, 32'h0000_80FF);
    @(negedge clk);
    dm_data_ok_in = 1'b0;
    dm_rdata_in = 32'h5A5A_5A5A;
    #1;
    check("lhu_done_state", {30'h0, dbg_state_out}, {30'h0, ST_DONE});
    check("lhu_done_allowin", {31'h0, mem_allowin_out}, 32'h0);
    check("lhu_done_valid", {31'h0, mem_valid_out}, 32'h1);
    check("lhu_done_buf", mem_wbdata_out, 32'h0000_80FF);
    @(negedge clk);
    dm_data_ok_in = 1'b1;   // ignored while DONE
    dm_rdata_in = 32'hA5A5_A5A5;
    #1;
    check("lhu_done_ignore", mem_wbdata_out, 32'h0000_80FF);
    wb_allowin_in = 1'b1;
    #1;
    check("lhu_release_allowin", {31'h0, mem_allowin_out}, 32'h1);
    check("lhu_release_data", mem_wbdata_out, 32'h0000_80FF);
    @(negedge clk);
    dm_data_ok_in = 1'b0;
    #1;
    check("lhu_after_state", {30'h0, dbg_state_out}, {30'h0, ST_IDLE});
    check("lhu_after_valid", {31'h0, mem_valid_out}, 32'h0);

    // reset while WAIT, then a stray data_ok
    drive_exe(1'b1, 5'b00010, 5'b00001, 8'h00, 32'h0000_2000, 32'h0, 5'd9, 32'h0000_3008);
    @(negedge clk);
    idle_exe();
    #1;
    check("rstw_state_pre", {30'h0, dbg_state_out}, {30'h0, ST_WAIT});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dm_rdata_in = 32'h1111_2222;
    dm_data_ok_in = 1'b1;
    #1;
    check("rstw_valid", {31'h0, mem_valid_out}, 32'h0);
    check("rstw_state", {30'h0, dbg_state_out}, {30'h0, ST_IDLE});
    check("rstw_allowin", {31'h0, mem_allowin_out}, 32'h1);
    @(negedge clk);
    dm_data_ok_in = 1'b0;
    #1;
    check("rstw_valid2", {31'h0, mem_valid_out}, 32'h0);
    check("rstw_state2", {30'h0, dbg_state_out}, {30'h0, ST_IDLE});

    // hi select held through a 3-cycle WB stall while EXE presses a follower
    drive_exe(1'b1, 5'b01000, 5'b00000, 8'h00, 32'h0000_0001, 32'h0, 5'd10, 32'h0000_300C);
    @(negedge clk);
    wb_allowin_in = 1'b0;
    drive_exe(1'b1, 5'b00001, 5'b00000, 8'h00, 32'h0000_0055, 32'h0, 5'd11, 32'h0000_3010);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("hi_stall_valid", {31'h0, mem_valid_out}, 32'h1);
      check("hi_stall_allowin", {31'h0, mem_allowin_out}, 32'h0);
      check("hi_stall_data", mem_wbdata_out, 32'hDEAD_BEEF);
      check("hi_stall_pc", mem_PC_out, 32'h0000_300C);
      @(negedge clk);
    end
    wb_allowin_in = 1'b1;
    #1;
    check("hi_release_allowin", {31'h0, mem_allowin_out}, 32'h1);
    @(negedge clk);
    idle_exe();
    #1;
    check("follow_valid", {31'h0, mem_valid_out}, 32'h1);
    check("follow_data", mem_wbdata_out, 32'h0000_0055);
    check("follow_pc", mem_PC_out, 32'h0000_3010);
    @(negedge clk);
    #1;
    check("drain_valid", {31'h0, mem_valid_out}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
